// File: rtl/stop_watch_pkg.sv
// Shared constants and digit helpers for the stopwatch/timer core.
// Digit order: d0 tenths, d1 sec units, d2 sec tens, d3.. minutes.
package stop_watch_pkg;

    localparam logic [3:0] DIG_MAX      = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    function automatic int nd_of(input int min_digits);
        return 3 + min_digits;
    endfunction

    function automatic logic [3:0] dig_top(input int idx);
        return (idx == 2) ? SEC_TENS_MAX : DIG_MAX;
    endfunction

    function automatic logic [3:0] dig_mod(input int idx);
        return dig_top(idx) + 4'd1;
    endfunction

endpackage

// File: rtl/stop_watch_lap_digit.sv
// One BCD digit of modulus MOD; wrap flags the digit that would carry
// (up, at MOD-1) or borrow (down, at 0) on the next enabled step.
module bcd_digit_cnt
    import stop_watch_pkg::*;
#(
    parameter logic [3:0] MOD = 4'd10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       up,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       wrap
);

    localparam logic [3:0] TOP = MOD - 4'd1;

    logic [3:0] q_q;
    logic [3:0] q_d;
    logic [3:0] ld_clamp;

    assign ld_clamp = (ld_val > TOP) ? TOP : ld_val;
    assign wrap     = up ? (q_q == TOP) : (q_q == 4'd0);
    assign q        = q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = 4'd0;
        end else if (load) begin
            q_d = ld_clamp;
        end else if (en) begin
            if (up) begin
                q_d = wrap ? 4'd0 : q_q + 4'd1;
            end else begin
                q_d = wrap ? TOP : q_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/stop_watch_lap.sv
// Stopwatch/countdown core: prescaler, BCD digit chain, limit detect,
// lap freeze register and display mux.
module stop_watch_lap
    import stop_watch_pkg::*;
#(
    parameter int TICK_DIV   = 10_000_000,
    parameter int MIN_DIGITS = 1,
    localparam int ND = nd_of(MIN_DIGITS),
    localparam int W  = 4 * ND
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         go,
    input  logic         clr,
    input  logic         up,
    input  logic         lap,
    input  logic         load,
    input  logic [W-1:0] load_d,
    output logic [W-1:0] d_bus,
    output logic         running,
    output logic         at_limit,
    output logic         lap_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [W-1:0]  cnt;
    logic [W-1:0]  lap_q;
    logic [W-1:0]  lap_d;
    logic          lap_act_q;
    logic          lap_act_d;
    logic [ND-1:0] wrap;
    logic [ND-1:0] en_c;
    logic          tick;
    logic          do_load;

    // Every digit at its carry/borrow point is exactly max (up) or zero (down).
    assign at_limit = &wrap;
    assign running  = go & ~at_limit;
    assign tick     = running & (presc_q == LAST);
    assign do_load  = load & ~go;
    assign en_c[0]  = tick;

    for (genvar i = 0; i < ND; i++) begin : g_dig
        bcd_digit_cnt #(
            .MOD (dig_mod(i))
        ) u_dig (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en_c[i]),
            .up      (up),
            .clr     (clr),
            .load    (do_load),
            .ld_val  (load_d[4*i +: 4]),
            .q       (cnt[4*i +: 4]),
            .wrap    (wrap[i])
        );
        if (i < ND - 1) begin : g_chain
            assign en_c[i+1] = en_c[i] & wrap[i];
        end
    end

    always_comb begin
        presc_d = presc_q;
        if (clr || do_load) begin
            presc_d = '0;
        end else if (running) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        lap_d     = lap_q;
        lap_act_d = lap_act_q;
        if (clr) begin
            lap_d     = '0;
            lap_act_d = 1'b0;
        end else if (lap) begin
            if (!lap_act_q) begin
                lap_d = cnt;
            end
            lap_act_d = ~lap_act_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            lap_q     <= '0;
            lap_act_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            lap_q     <= lap_d;
            lap_act_q <= lap_act_d;
        end
    end

    assign d_bus      = lap_act_q ? lap_q : cnt;
    assign lap_active = lap_act_q;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Directed bench for stop_watch_lap with TICK_DIV=4, one minute digit.
module tb_stop_watch_lap;

    logic        clk;
    logic        reset_n;
    logic        go;
    logic        clr;
    logic        up;
    logic        lap;
    logic        load;
    logic [15:0] load_d;
    logic [15:0] d_bus;
    logic        running;
    logic        at_limit;
    logic        lap_active;

    int n_chk;
    int n_err;

    stop_watch_lap #(
        .TICK_DIV   (4),
        .MIN_DIGITS (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .clr        (clr),
        .up         (up),
        .lap        (lap),
        .load       (load),
        .load_d     (load_d),
        .d_bus      (d_bus),
        .running    (running),
        .at_limit   (at_limit),
        .lap_active (lap_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // tenths of a second -> M.SS.D BCD
    function automatic logic [15:0] bcd(input int t);
        int s;
        s = t / 10;
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    initial begin
        n_chk   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        go      = 1'b0;
        clr     = 1'b0;
        up      = 1'b1;
        lap     = 1'b0;
        load    = 1'b0;
        load_d  = 16'h0000;
        cyc(2);
        check("rst_dbus", d_bus, 16'h0000);
        check("rst_run", running, 0);
        check("rst_lim_up", at_limit, 0);
        check("rst_lap", lap_active, 0);
        up = 1'b0;
        #1;
        check("rst_lim_dn", at_limit, 1);
        up = 1'b1;
        reset_n = 1'b1;
        cyc(1);

        go = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cyc(1);
            check($sformatf("up_cyc%0d", i), d_bus, bcd(i / 4));
        end

        go     = 1'b0;
        load_d = 16'h9597;
        load   = 1'b1;
        cyc(1);
        load = 1'b0;
        check("ld_9597", d_bus, 16'h9597);
        go = 1'b1;
        cyc(4);
        check("max_9598", d_bus, 16'h9598);
        cyc(4);
        check("max_9599", d_bus, 16'h9599);
        check("max_lim", at_limit, 1);
        check("max_run", running, 0);
        cyc(8);
        check("max_hold", d_bus, 16'h9599);

        go     = 1'b0;
        up     = 1'b0;
        load_d = 16'h0003;
        load   = 1'b1;
        cyc(1);
        load = 1'b0;
        check("ld_0003", d_bus, 16'h0003);
        go = 1'b1;
        cyc(4);
        check("dn_0002", d_bus, 16'h0002);
        cyc(4);
        check("dn_0001", d_bus, 16'h0001);
        cyc(4);
        check("dn_0000", d_bus, 16'h0000);
        check("dn_lim", at_limit, 1);
        check("dn_run", running, 0);
        cyc(8);
        check("dn_hold", d_bus, 16'h0000);
        up = 1'b1;
        #1;
        check("flip_lim", at_limit, 0);
        go     = 1'b0;
        load_d = 16'h07AF;
        load   = 1'b1;
        cyc(1);
        load = 1'b0;
        check("ld_clamp", d_bus, 16'h0599);

        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clr_go0", d_bus, 16'h0000);
        go = 1'b1;
        cyc(100);
        check("lap_pre", d_bus, 16'h0025);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("lap1_val", d_bus, 16'h0025);
        check("lap1_act", lap_active, 1);
        cyc(79);
        check("lap_frozen", d_bus, 16'h0025);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("lap2_val", d_bus, 16'h0045);
        check("lap2_act", lap_active, 0);
        cyc(2);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("lap_tick", d_bus, 16'h0045);
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        check("lap_live", d_bus, 16'h0046);

        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(120);
        check("run_0030", d_bus, 16'h0030);
        cyc(3);
        check("pre_clr", d_bus, 16'h0030);
        clr = 1'b1;
        lap = 1'b1;
        cyc(1);
        clr = 1'b0;
        lap = 1'b0;
        check("clr_dbus", d_bus, 16'h0000);
        check("clr_lap", lap_active, 0);
        cyc(3);
        check("clr_p3", d_bus, 16'h0000);
        cyc(1);
        check("clr_p4", d_bus, 16'h0001);
        load_d = 16'h5555;
        load   = 1'b1;
        cyc(1);
        load = 1'b0;
        check("ld_go1", d_bus, 16'h0001);
        cyc(3);
        check("ld_go1_pre", d_bus, 16'h0002);

        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        cyc(492);
        check("run_0123", d_bus, 16'h0123);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_dbus", d_bus, 16'h0000);
        check("arst_lap", lap_active, 0);
        go = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(10);
        check("pause_dbus", d_bus, 16'h0000);
        check("pause_run", running, 0);
        go = 1'b1;
        cyc(4);
        check("resume", d_bus, 16'h0001);
        check("resume_run", running, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
